// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared types and constants for mod_reconstruct
package mod_pkg;

  localparam int DATAWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mod_reconstruct.sv
// rtl/mod_reconstruct.sv - rebuilds a = q*b + r by shift-add, one quotient bit per cycle
// Optional operand-consistency flag enabled by MOD_RECONSTRUCT_CHECK_EN.
module mod_reconstruct
  import mod_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic [DATAWIDTH-1:0]     q,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic [DATAWIDTH-1:0]     r,
  output logic [2*DATAWIDTH-1:0]   a,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = cnt_width(DATAWIDTH);
  localparam int AW = 2 * DATAWIDTH;

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] q_sh_q, q_sh_d;
  logic [AW-1:0]        b_sh_q, b_sh_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        a_q, a_d;
  logic [AW-1:0]        sum;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 load;

  always_comb begin
    state_d = state_q;
    q_sh_d  = q_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    load    = 1'b0;
    sum     = q_sh_q[0] ? (acc_q + b_sh_q) : acc_q;

    case (state_q)
      IDLE: load = start;
      RUN: begin
        acc_d  = sum;
        b_sh_d = b_sh_q << 1;
        q_sh_d = q_sh_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          a_d     = sum;
          state_d = DONE;
        end
      end
      DONE: begin
        load    = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Capture shared by IDLE and DONE so back-to-back starts lose no cycle.
    if (load) begin
      q_sh_d  = q;
      b_sh_d  = AW'(b);
      acc_d   = AW'(r);
      cnt_d   = CW'(DATAWIDTH);
      state_d = RUN;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      q_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
    end
  end

  assign a    = a_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef MOD_RECONSTRUCT_CHECK_EN
  logic bad_q, bad_d;

  always_comb begin
    bad_d = bad_q;
    if (load) bad_d = (b == '0) || (r >= b);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) bad_q <= 1'b0;
    else     bad_q <= bad_d;
  end

  assign err = done & bad_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_reconstruct.sv
// tb/tb_mod_reconstruct.sv - self-checking bench for mod_reconstruct
module tb_mod_reconstruct;

  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] q = '0, b = '0, r = '0;
  logic [2*DW-1:0] a;
  logic          busy, done, err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2*DW-1:0] ea;
    logic            ee;
  } exp_t;

  exp_t exp_q[$];

  mod_reconstruct #(.DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .q(q), .b(b), .r(r),
    .a(a), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [DW-1:0] bv, input logic [DW-1:0] rv);
`ifdef MOD_RECONSTRUCT_CHECK_EN
    return (bv == '0) || (rv >= bv);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2*DW-1:0] model(input logic [DW-1:0] qv, input logic [DW-1:0] bv,
                                            input logic [DW-1:0] rv);
    return (2*DW)'(qv) * (2*DW)'(bv) + (2*DW)'(rv);
  endfunction

  // One isolated operation; operands are scrambled while the block runs.
  task automatic do_op(input logic [DW-1:0] qv, input logic [DW-1:0] bv,
                       input logic [DW-1:0] rv, input string tag);
    int k;
    int busy_cnt;
    logic [2*DW-1:0] held;
    @(negedge Clk);
    q = qv; b = bv; r = rv; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (k < 20 && !done) begin
      if (busy) busy_cnt++;
      q = DW'($urandom); b = DW'($urandom); r = DW'($urandom);
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      @(negedge Clk);
      k++;
    end
    check({tag, "_latency"}, k, DW);
    check({tag, "_busy_cycles"}, busy_cnt, DW);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_a"}, a, model(qv, bv, rv));
    check({tag, "_err"}, err, exp_err(bv, rv));
    held = a;
    @(negedge Clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_a_held"}, a, held);
    check({tag, "_err_cleared"}, err, 0);
  endtask

  initial begin
    int nres;
    int c;
    exp_t e;

    #2;
    check("reset_a", a, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    @(negedge Clk);
    Rst = 1'b0;

    do_op(8'd3,   8'd2,   8'd1,   "t3x2p1");
    do_op(8'd5,   8'd5,   8'd0,   "t5x5");
    do_op(8'd0,   8'd13,  8'd5,   "tq0");
    do_op(8'd39,  8'd1,   8'd0,   "tb1");
    do_op(8'd255, 8'd255, 8'd254, "tmax");
    do_op(8'd1,   8'd5,   8'd13,  "tbad_r");
    do_op(8'd7,   8'd0,   8'd4,   "tb0");
    for (int i = 0; i < 10; i++)
      do_op(DW'($urandom), DW'($urandom), DW'($urandom), "trand");

    // Start held high: captures every DW+1 cycles with operands changing each cycle.
    nres = 0;
    @(negedge Clk);
    for (c = 0; c <= 40; c++) begin
      start = (c < 30);
      q = DW'($urandom); b = DW'($urandom); r = DW'($urandom);
      if (start && (c % (DW + 1) == 0)) begin
        e.ea = model(q, b, r);
        e.ee = exp_err(b, r);
        exp_q.push_back(e);
      end
      @(negedge Clk);
      if (done) begin
        nres++;
        check("stream_phase", c % (DW + 1), DW);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("stream_a", a, e.ea);
          check("stream_err", err, e.ee);
        end else begin
          check("stream_extra_result", 1, 0);
        end
      end
    end
    check("stream_count", nres, 4);
    check("stream_pending", exp_q.size(), 0);

    // Reset in the middle of RUN discards the partial result.
    @(negedge Clk);
    q = 8'd9; b = 8'd9; r = 8'd2; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    check("pre_reset_busy", busy, 1);
    #1 Rst = 1'b1;
    #1;
    check("rst_a", a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("post_reset_idle", busy, 0);
    do_op(8'd3, 8'd2, 8'd1, "tafter_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_reconstruct.md
# mod_reconstruct

Sequential inverse of the combinational `MOD` remainder unit. Given a quotient `q`, divisor `b` and remainder `r`, it rebuilds the dividend `a = q*b + r` with a shift-add multiplier, one quotient bit per cycle. It sits beside `MOD`/`DIV` in the component library. It is used by datapath benches and schedulers that need to regenerate or cross-check a dividend from `DIV`/`MOD` results.

## Interface
- `DATAWIDTH`, default 8: width of `q`, `b`, `r`; result width is 2*DATAWIDTH.
- `Clk` input 1: rising-edge clock; the block uses one clock.
- `Rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only when the block is not in RUN.
- `q` input DATAWIDTH: quotient operand.
- `b` input DATAWIDTH: divisor operand.
- `r` input DATAWIDTH: remainder operand.
- `a` output 2*DATAWIDTH: reconstructed dividend; registered and held until the next result.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when `a` is valid.
- `err` output 1: operand-consistency flag, valid with `done` (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is held in the package.
- IDLE:
  - `start`=1 on an edge: capture `q` into `q_sh`, `b` zero-extended to 2*DATAWIDTH into `b_sh`, `r` zero-extended into `acc`.
  - Same edge: load `cnt` = DATAWIDTH, go to RUN.
- RUN, each edge:
  - If `q_sh[0]`: `acc <= acc + b_sh`.
  - `b_sh <= b_sh << 1`, `q_sh <= q_sh >> 1`, `cnt <= cnt - 1`.
  - On the edge where `cnt` goes 1→0: `a <= final acc`, go to DONE.
- DONE: `done`=1 for exactly this cycle.
  - `start`=1: capture new operands and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `start` in RUN is ignored; operands are not re-sampled.
- Arithmetic is unsigned, 2*DATAWIDTH wide, and never overflows: max = (2^N−1)^2 + (2^N−1) = 2^2N − 2^N.
- Iteration count is fixed; there is no early exit when `q_sh` reaches 0.
- `b`=0 gives `a` = `r`. `q`=0 gives `a` = `r`.
- `Rst` asserted at any time, including mid-RUN:
  - State goes to IDLE immediately.
  - `a`, `busy`, `done`, `err` and all internal registers go to 0.
  - The partial result is discarded.

## Timing
- Reset values: `a`=0, `busy`=0, `done`=0, `err`=0.
- Latency: `start` is sampled at edge E0; `a`, `done` and `err` become visible after edge E(DATAWIDTH), i.e. DATAWIDTH cycles later.
- `busy` is high for the DATAWIDTH cycles after E0 and low in DONE.
- Throughput: one result per DATAWIDTH+1 cycles with `start` held high.
- `a` changes only on the DONE-entry edge or on reset.
- `done` never stays high for two consecutive cycles.

## Configuration
- Macro: `MOD_RECONSTRUCT_CHECK_EN`.
- Defined:
  - At capture, register `bad` = (`b` == 0) or (`r` >= `b`).
  - `err` = `bad` during the DONE cycle, 0 otherwise.
  - `a` is still computed normally.
- Undefined: `err` is tied to 0 and the comparator logic is absent.

## Structure
- Shared package `mod_pkg`:
  - state enum (IDLE/RUN/DONE);
  - default DATAWIDTH constant;
  - counter width = $clog2(DATAWIDTH+1).
- Single module; no sub-module is warranted. The datapath is one adder and two shifters.

## Test plan
- q=3, b=2, r=1, pulse `start` → after 8 cycles: `done` pulse, `a`=7, `err`=0. Same pattern for q=5, b=5, r=0 → `a`=25.
- q=0, b=13, r=5 → `a`=5. Then q=39, b=1, r=0 → `a`=39. Check `busy` is high exactly 8 cycles each.
- q=255, b=255, r=254 → `a`=65279. No truncation in the 16-bit result.
- `start` held high for 30 cycles with changing operands:
  - results arrive every 9 cycles;
  - each result matches the operands captured at IDLE/DONE;
  - operand changes during RUN have no effect.
- `Rst` asserted at RUN cycle 4 → outputs 0 immediately, state IDLE. A subsequent q=3, b=2, r=1 gives 7 with the normal latency.
- `MOD_RECONSTRUCT_CHECK_EN` defined:
  - q=1, b=5, r=13 → `err`=1 with `done`, `a`=18.
  - b=0, r=4 → `err`=1, `a`=4.
  - Undefined build, same stimulus → `err` stays 0.
